wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the pipeline WB stage
//  (fed by the MEM/WB pipeline register) and a long-latency multiply/divide
//  unit (MDU). The pipeline has priority. MDU results wait in a small FIFO.
//  An anti-starvation counter stalls WB for one cycle so a waiting MDU result
//  is eventually written.
//  Also reports to the hazard unit when a decode source register has a
//  pending MDU write.
// PARAMETERS
//  DATA_W        32  register data width
//  ADDR_W        5   register address width
//  FIFO_DEPTH    2   MDU result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4   consecutive denied cycles before a forced drain (>=1)
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high reset
//  regwrite_W    in   1       WB stage requests a register write
//  writereg_W    in   ADDR_W  WB destination register
//  result_W      in   DATA_W  WB write data
//  mdu_valid     in   1       MDU offers a result
//  mdu_writereg  in   ADDR_W  MDU destination register
//  mdu_result    in   DATA_W  MDU result data
//  mdu_ready     out  1       FIFO can accept (= !full)
//  query_reg     in   ADDR_W  decode source register to check
//  pend_hit      out  1       query_reg matches a valid FIFO entry
//  stall_W       out  1       registered; hold MEM/WB and earlier stages
//  rf_we         out  1       register-file write enable
//  rf_wa         out  ADDR_W  register-file write address
//  rf_wd         out  DATA_W  register-file write data
// BEHAVIOUR
//  Reset: FIFO emptied, starve_cnt=0, state=NORM, stall_W=0. While reset=1,
//   rf_we=0, rf_wa=0, rf_wd=0, pend_hit=0 and mdu_ready=0.
//   mdu_ready=1 in the first cycle after reset is released.
//  Pipeline request: wb_req = regwrite_W && writereg_W!=0.
//   A write to $0 is not a request.
//  MDU handshake: a result is accepted when mdu_valid && mdu_ready at the clock
//   edge. mdu_ready depends only on the registered count. When full there is no
//   push, even if a pop happens in the same cycle. An accepted result with
//   mdu_writereg==0 is dropped and never enqueued.
//  No bypass. An MDU result is written at the earliest 1 cycle after it is
//   accepted.
//  States: NORM and DRAIN. stall_W = (state==DRAIN).
//  NORM, combinational grant:
//   - wb_req: rf_* = WB inputs, rf_we=1.
//     If the FIFO is not empty, starve_cnt++ (saturating).
//   - else if the FIFO is not empty: rf_* = head, rf_we=1, pop, starve_cnt=0.
//   - else: rf_we=0 and starve_cnt=0.
//   - NORM->DRAIN at the edge where the updated starve_cnt == STARVE_LIMIT.
//  DRAIN (exactly one cycle): the WB inputs are ignored (pipeline is frozen and
//   re-presents them). rf_* = head, rf_we=1, pop, starve_cnt=0, then -> NORM.
//  rf_wa/rf_wd = 0 whenever rf_we=0.
//  pend_hit = OR over valid entries of (entry.reg==query_reg), forced 0 when
//   query_reg==0. Purely combinational.
//  FIFO pointers wrap modulo FIFO_DEPTH. Push into the slot just freed by a
//   same-cycle pop is legal only when the FIFO was not full.
//  Reset mid-DRAIN or with entries pending: all pending results are discarded;
//   the next cycle is NORM with stall_W=0.
// TESTING
//  T1 reset held 3 cycles -> rf_we=0, stall_W=0, mdu_ready=0;
//     first cycle after release -> mdu_ready=1.
//  T2 idle WB; MDU pushes reg 8 / 0xDEADBEEF at cycle t ->
//     t+1: rf_we=1, rf_wa=8, rf_wd=0xDEADBEEF; t+2: rf_we=0.
//  T3 WB writes reg 3 every cycle; MDU pushes reg 9 at t; STARVE_LIMIT=4 ->
//     t+1..t+4 write reg 3; t+5: stall_W=1, rf_wa=9; t+6: reg 3 again.
//  T4 WB busy; MDU pushes regs 10 and 11 back-to-back -> mdu_ready=0 on the
//     next cycle; pend_hit=1 for query_reg=11; a third result is held until a pop.
//  T5 MDU pushes reg 0 / 0x1234 with WB idle -> no rf write, FIFO empty,
//     pend_hit=0.
//  T6 reset asserted during a DRAIN cycle -> next cycle stall_W=0, FIFO empty,
//     no write of the pending entry.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between the WB stage and MDU results
// Pipeline writes win; queued MDU results drain on idle WB cycles or via a one-cycle forced stall.
module wb_port_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regwrite_W,
   input  logic [ADDR_W-1:0] writereg_W,
   input  logic [DATA_W-1:0] result_W,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_writereg,
   input  logic [DATA_W-1:0] mdu_result,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] query_reg,
   output logic              pend_hit,
   output logic              stall_W,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {NORM, DRAIN} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] fifo_reg [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_dat [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [SC_W-1:0]   starve_cnt, starve_nx;
   logic [PTR_W-1:0]  offs [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] entry_valid;
   logic              wb_req, empty, full, push, pop;

   assign wb_req    = regwrite_W && (writereg_W != '0);
   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign mdu_ready = !reset && !full;
   // Results aimed at $0 are handshaken but silently dropped.
   assign push      = mdu_valid && mdu_ready && (mdu_writereg != '0);
   assign stall_W   = (state == DRAIN);

   for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_valid
      assign offs[g]        = PTR_W'(g) - rd_ptr;
      assign entry_valid[g] = ({1'b0, offs[g]} < count);
   end

   always_comb begin
      pend_hit = 1'b0;
      if (!reset && (query_reg != '0)) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && (fifo_reg[i] == query_reg)) pend_hit = 1'b1;
         end
      end
   end

   always_comb begin
      rf_we     = 1'b0;
      rf_wa     = '0;
      rf_wd     = '0;
      pop       = 1'b0;
      starve_nx = starve_cnt;
      state_nx  = state;
      if (!reset) begin
         case (state)
            DRAIN: begin
               if (!empty) begin
                  rf_we = 1'b1;
                  rf_wa = fifo_reg[rd_ptr];
                  rf_wd = fifo_dat[rd_ptr];
                  pop   = 1'b1;
               end
               starve_nx = '0;
               state_nx  = NORM;
            end
            default: begin
               if (wb_req) begin
                  rf_we = 1'b1;
                  rf_wa = writereg_W;
                  rf_wd = result_W;
                  if (!empty && (starve_cnt != SC_W'(STARVE_LIMIT)))
                     starve_nx = starve_cnt + SC_W'(1);
                  if (!empty && (starve_nx == SC_W'(STARVE_LIMIT)))
                     state_nx = DRAIN;
               end else if (!empty) begin
                  rf_we     = 1'b1;
                  rf_wa     = fifo_reg[rd_ptr];
                  rf_wd     = fifo_dat[rd_ptr];
                  pop       = 1'b1;
                  starve_nx = '0;
               end else begin
                  starve_nx = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= NORM;
         starve_cnt <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
      end else begin
         state      <= state_nx;
         starve_cnt <= starve_nx;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Storage needs no reset: occupancy is tracked solely by count and the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_reg[wr_ptr] <= mdu_writereg;
         fifo_dat[wr_ptr] <= mdu_result;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
// Directed vector table, hand sequences for multi-cycle corners, then random stimulus against a queue model.
module tb_wb_port_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset, regwrite_W, mdu_valid;
   logic [4:0]  writereg_W, mdu_writereg, query_reg;
   logic [31:0] result_W, mdu_result;
   logic        mdu_ready, pend_hit, stall_W, rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset), .regwrite_W(regwrite_W), .writereg_W(writereg_W),
      .result_W(result_W), .mdu_valid(mdu_valid), .mdu_writereg(mdu_writereg),
      .mdu_result(mdu_result), .mdu_ready(mdu_ready), .query_reg(query_reg),
      .pend_hit(pend_hit), .stall_W(stall_W), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_model = 1'b0;

   typedef struct {
      logic rst, rw; logic [4:0] wreg; logic [31:0] wres;
      logic mv; logic [4:0] mreg; logic [31:0] mres; logic [4:0] q;
      logic we; logic [4:0] wa; logic [31:0] wd; logic stall, rdy, hit;
   } vec_t;
   vec_t tbl[$];

   // Reference model: FIFO as queues, starvation as a plain integer.
   logic [4:0]  mq_reg[$];
   logic [31:0] mq_dat[$];
   int          m_starve = 0, m_nstarve;
   bit          m_drain = 0, m_ndrain, m_pop, m_push;
   logic        m_we, m_stall, m_rdy, m_hit;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic vec_t v(logic rst, logic rw, logic [4:0] wreg, logic [31:0] wres,
                              logic mv, logic [4:0] mreg, logic [31:0] mres, logic [4:0] q,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic stall, logic rdy, logic hit);
      vec_t r;
      r.rst = rst; r.rw = rw; r.wreg = wreg; r.wres = wres; r.mv = mv; r.mreg = mreg;
      r.mres = mres; r.q = q; r.we = we; r.wa = wa; r.wd = wd; r.stall = stall;
      r.rdy = rdy; r.hit = hit;
      return r;
   endfunction

   task automatic sample();
      @(negedge clk);
      m_we = 0; m_wa = 0; m_wd = 0; m_pop = 0; m_push = 0; m_hit = 0; m_rdy = 0;
      m_nstarve = m_starve; m_ndrain = 0;
      m_stall = m_drain;
      if (!reset) begin
         m_rdy = (mq_reg.size() < DEPTH);
         if (query_reg != 0) foreach (mq_reg[i]) if (mq_reg[i] == query_reg) m_hit = 1;
         if (m_drain) begin
            m_we = 1; m_wa = mq_reg[0]; m_wd = mq_dat[0]; m_pop = 1; m_nstarve = 0;
         end else if (regwrite_W && writereg_W != 0) begin
            m_we = 1; m_wa = writereg_W; m_wd = result_W;
            if (mq_reg.size() > 0) m_nstarve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            m_ndrain = (mq_reg.size() > 0) && (m_nstarve == LIMIT);
         end else if (mq_reg.size() > 0) begin
            m_we = 1; m_wa = mq_reg[0]; m_wd = mq_dat[0]; m_pop = 1; m_nstarve = 0;
         end else begin
            m_nstarve = 0;
         end
         m_push = mdu_valid && m_rdy && (mdu_writereg != 0);
      end
      if (chk_model) begin
         chk("m_rf_we", rf_we, m_we);
         chk("m_rf_wa", rf_wa, m_wa);
         chk("m_rf_wd", rf_wd, m_wd);
         chk("m_stall_W", stall_W, m_stall);
         chk("m_mdu_ready", mdu_ready, m_rdy);
         chk("m_pend_hit", pend_hit, m_hit);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) begin
         mq_reg.delete(); mq_dat.delete(); m_starve = 0; m_drain = 0;
      end else begin
         if (m_pop) begin mq_reg.delete(0); mq_dat.delete(0); end
         if (m_push) begin mq_reg.push_back(mdu_writereg); mq_dat.push_back(mdu_result); end
         m_starve = m_nstarve; m_drain = m_ndrain;
      end
      #1;
   endtask

   task automatic set_in(logic rst, logic rw, logic [4:0] wreg, logic [31:0] wres,
                         logic mv, logic [4:0] mreg, logic [31:0] mres, logic [4:0] q);
      reset = rst; regwrite_W = rw; writereg_W = wreg; result_W = wres;
      mdu_valid = mv; mdu_writereg = mreg; mdu_result = mres; query_reg = q;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      set_in(1, 0, 0, 0, 0, 0, 0, 0);

      // T1 reset, T2 idle push, T3 starvation drain, T5 $0 drop, WB $0 not a request
      for (int i = 0; i < 3; i++) tbl.push_back(v(1,0,0,0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
      tbl.push_back(v(0,0,0,0,1,8,32'hDEADBEEF,8, 0,0,0,0,1,0));
      tbl.push_back(v(0,0,0,0,0,0,0,8, 1,8,32'hDEADBEEF,0,1,1));
      tbl.push_back(v(0,0,0,0,0,0,0,8, 0,0,0,0,1,0));
      tbl.push_back(v(0,1,3,32'h33,1,9,32'h99,9, 1,3,32'h33,0,1,0));
      for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,3,32'h33,0,0,0,9, 1,3,32'h33,0,1,1));
      tbl.push_back(v(0,1,3,32'h33,0,0,0,9, 1,9,32'h99,1,1,1));
      tbl.push_back(v(0,1,3,32'h33,0,0,0,9, 1,3,32'h33,0,1,0));
      tbl.push_back(v(0,0,0,0,1,0,32'h1234,0, 0,0,0,0,1,0));
      tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
      tbl.push_back(v(0,1,0,32'h55,0,0,0,0, 0,0,0,0,1,0));

      foreach (tbl[i]) begin
         set_in(tbl[i].rst, tbl[i].rw, tbl[i].wreg, tbl[i].wres,
                tbl[i].mv, tbl[i].mreg, tbl[i].mres, tbl[i].q);
         sample();
         chk($sformatf("v%0d_rf_we", i), rf_we, tbl[i].we);
         chk($sformatf("v%0d_rf_wa", i), rf_wa, tbl[i].wa);
         chk($sformatf("v%0d_rf_wd", i), rf_wd, tbl[i].wd);
         chk($sformatf("v%0d_stall_W", i), stall_W, tbl[i].stall);
         chk($sformatf("v%0d_mdu_ready", i), mdu_ready, tbl[i].rdy);
         chk($sformatf("v%0d_pend_hit", i), pend_hit, tbl[i].hit);
         advance();
      end

      chk_model = 1'b1;

      // T4: back-to-back pushes fill the FIFO; a third result waits for a pop
      set_in(1, 0, 0, 0, 0, 0, 0, 0); sample(); advance();
      set_in(0, 1, 3, 32'h33, 1, 10, 32'hA0, 0); sample(); chk("t4_rdy_a", mdu_ready, 1); advance();
      set_in(0, 1, 3, 32'h33, 1, 11, 32'hB0, 0); sample(); chk("t4_rdy_b", mdu_ready, 1); advance();
      set_in(0, 1, 3, 32'h33, 1, 12, 32'hC0, 11); sample();
      chk("t4_full", mdu_ready, 0); chk("t4_hit11", pend_hit, 1); advance();
      sample(); chk("t4_held_d", mdu_ready, 0); advance();
      sample(); chk("t4_held_e", mdu_ready, 0); advance();
      sample(); chk("t4_drain_stall", stall_W, 1); chk("t4_drain_wa", rf_wa, 10);
      chk("t4_held_f", mdu_ready, 0); advance();
      sample(); chk("t4_rdy_g", mdu_ready, 1); chk("t4_wb_g", rf_wa, 3); advance();
      set_in(0, 0, 0, 0, 0, 0, 0, 12);
      sample(); chk("t4_wa11", rf_wa, 11); chk("t4_hit12", pend_hit, 1); advance();
      sample(); chk("t4_wa12", rf_wa, 12); chk("t4_wd12", rf_wd, 32'hC0); advance();
      sample(); chk("t4_empty_we", rf_we, 0); advance();

      // T6: reset landing on the DRAIN cycle discards the pending entry
      set_in(1, 0, 0, 0, 0, 0, 0, 0); sample(); advance();
      set_in(0, 1, 3, 32'h33, 1, 20, 32'h20, 20); sample(); advance();
      mdu_valid = 0;
      found = 0;
      for (int k = 0; k < 10; k++) begin
         if (stall_W) begin found = 1; break; end
         sample(); advance();
      end
      chk("t6_reach_drain", found, 1);
      reset = 1;
      sample(); chk("t6_rst_we", rf_we, 0); chk("t6_rst_hit", pend_hit, 0);
      chk("t6_rst_rdy", mdu_ready, 0); advance();
      set_in(0, 0, 0, 0, 0, 0, 0, 20);
      sample(); chk("t6_stall", stall_W, 0); chk("t6_we", rf_we, 0);
      chk("t6_hit", pend_hit, 0); chk("t6_rdy", mdu_ready, 1); advance();
      sample(); chk("t6_we2", rf_we, 0); advance();

      // Random traffic against the model
      set_in(1, 0, 0, 0, 0, 0, 0, 0); sample(); advance();
      for (int n = 0; n < 400; n++) begin
         set_in($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)));
         sample();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
